// File: rtl/move_special_ctrl.sv
// rtl/move_special_ctrl.sv - fetch/execute sequencer for MFHI/MFLO/MTHI/MTLO/IN/OUT
// Moore-style control decode of the current state; ir_opcode only matters in T3.
module move_special_ctrl #(
   parameter int         MEM_WAIT = 1,
   parameter int         CW       = 8,
   parameter logic [4:0] OP_MFHI  = 5'b11000,
   parameter logic [4:0] OP_MFLO  = 5'b11001,
   parameter logic [4:0] OP_MTHI  = 5'b11010,
   parameter logic [4:0] OP_MTLO  = 5'b11011,
   parameter logic [4:0] OP_IN    = 5'b10110,
   parameter logic [4:0] OP_OUT   = 5'b10111
) (
   input  logic          Clock,
   input  logic          clr,
   input  logic          start,
   input  logic [4:0]    ir_opcode,
   output logic          PC_out,
   output logic          MAR_enable,
   output logic          PC_enable,
   output logic          IncPC,
   output logic          Read,
   output logic          MDR_enable,
   output logic          MDR_out,
   output logic          IR_enable,
   output logic          HI_out,
   output logic          LO_out,
   output logic          in_port_out,
   output logic          Gra,
   output logic          R_in,
   output logic          R_out,
   output logic          HI_enable,
   output logic          LO_enable,
   output logic          out_port_enable,
   output logic          busy,
   output logic          done,
   output logic          illegal,
   output logic [CW-1:0] instr_count
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T0   = 3'd1,
      S_T1   = 3'd2,
      S_T2   = 3'd3,
      S_T3   = 3'd4,
      S_DONE = 3'd5
   } state_t;

   localparam int            WW        = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
   localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_WAIT - 1);

   state_t        state_q, state_d;
   logic [WW-1:0] wait_q, wait_d;
   logic          illegal_q, illegal_d;
   logic [CW-1:0] count_q, count_d;
   logic          op_legal;

   always_ff @(posedge Clock or negedge clr) begin
      if (!clr) begin
         state_q   <= S_IDLE;
         wait_q    <= '0;
         illegal_q <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         illegal_q <= illegal_d;
         count_q   <= count_d;
      end
   end

   always_comb begin
      op_legal = (ir_opcode == OP_MFHI) || (ir_opcode == OP_MFLO) ||
                 (ir_opcode == OP_MTHI) || (ir_opcode == OP_MTLO) ||
                 (ir_opcode == OP_IN)   || (ir_opcode == OP_OUT);
   end

   // Wait counter runs only while in T1 and is cleared in every other state.
   always_comb begin
      state_d = state_q;
      wait_d  = '0;
      case (state_q)
         S_IDLE: if (start) state_d = S_T0;
         S_T0:   state_d = S_T1;
         S_T1: begin
            if (wait_q == WAIT_LAST) state_d = S_T2;
            else                     wait_d  = wait_q + WW'(1);
         end
         S_T2:   state_d = S_T3;
         S_T3:   state_d = S_DONE;
         S_DONE: state_d = start ? S_T0 : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      illegal_d = illegal_q | ((state_q == S_T3) && !op_legal);
      count_d   = count_q;
      if ((state_q == S_DONE) && (count_q != {CW{1'b1}}))
         count_d = count_q + CW'(1);
   end

   always_comb begin
      PC_out          = 1'b0;
      MAR_enable      = 1'b0;
      PC_enable       = 1'b0;
      IncPC           = 1'b0;
      Read            = 1'b0;
      MDR_enable      = 1'b0;
      MDR_out         = 1'b0;
      IR_enable       = 1'b0;
      HI_out          = 1'b0;
      LO_out          = 1'b0;
      in_port_out     = 1'b0;
      Gra             = 1'b0;
      R_in            = 1'b0;
      R_out           = 1'b0;
      HI_enable       = 1'b0;
      LO_enable       = 1'b0;
      out_port_enable = 1'b0;
      busy            = 1'b0;
      done            = 1'b0;
      case (state_q)
         S_T0: begin
            busy       = 1'b1;
            PC_out     = 1'b1;
            MAR_enable = 1'b1;
            PC_enable  = 1'b1;
            IncPC      = 1'b1;
         end
         S_T1: begin
            busy       = 1'b1;
            Read       = 1'b1;
            MDR_enable = 1'b1;
         end
         S_T2: begin
            busy      = 1'b1;
            MDR_out   = 1'b1;
            IR_enable = 1'b1;
         end
         S_T3: begin
            busy = 1'b1;
            // Exactly one bus driver per opcode; unsupported opcodes drive nothing.
            if (ir_opcode == OP_MFHI) begin
               HI_out = 1'b1; Gra = 1'b1; R_in = 1'b1;
            end else if (ir_opcode == OP_MFLO) begin
               LO_out = 1'b1; Gra = 1'b1; R_in = 1'b1;
            end else if (ir_opcode == OP_IN) begin
               in_port_out = 1'b1; Gra = 1'b1; R_in = 1'b1;
            end else if (ir_opcode == OP_MTHI) begin
               Gra = 1'b1; R_out = 1'b1; HI_enable = 1'b1;
            end else if (ir_opcode == OP_MTLO) begin
               Gra = 1'b1; R_out = 1'b1; LO_enable = 1'b1;
            end else if (ir_opcode == OP_OUT) begin
               Gra = 1'b1; R_out = 1'b1; out_port_enable = 1'b1;
            end
         end
         S_DONE: done = 1'b1;
         default: ;
      endcase
   end

   assign illegal     = illegal_q;
   assign instr_count = count_q;

endmodule

// File: tb/tb_move_special_ctrl.sv
// tb/tb_move_special_ctrl.sv - three-configuration bench with cycle-position reference model
// Instances: (MEM_WAIT=1,CW=8), (MEM_WAIT=3,CW=8), (MEM_WAIT=2,CW=2), all sharing one stimulus.
module tb_move_special_ctrl;

   localparam logic [4:0] OP_MFHI = 5'b11000;
   localparam logic [4:0] OP_MFLO = 5'b11001;
   localparam logic [4:0] OP_MTHI = 5'b11010;
   localparam logic [4:0] OP_MTLO = 5'b11011;
   localparam logic [4:0] OP_IN   = 5'b10110;
   localparam logic [4:0] OP_OUT  = 5'b10111;

   // Bit order: PC_out MAR_en PC_en IncPC | Read MDR_en MDR_out IR_en | HI_out LO_out in_out Gra |
   //            R_in R_out HI_en LO_en | out_en busy done
   localparam logic [18:0] M_T0   = 19'b1111_0000_0000_0000_010;
   localparam logic [18:0] M_T1   = 19'b0000_1100_0000_0000_010;
   localparam logic [18:0] M_T2   = 19'b0000_0011_0000_0000_010;
   localparam logic [18:0] M_BUSY = 19'b0000_0000_0000_0000_010;
   localparam logic [18:0] M_DONE = 19'b0000_0000_0000_0000_001;
   localparam logic [18:0] X_MFHI = 19'b0000_0000_1001_1000_000;
   localparam logic [18:0] X_MFLO = 19'b0000_0000_0101_1000_000;
   localparam logic [18:0] X_IN   = 19'b0000_0000_0011_1000_000;
   localparam logic [18:0] X_MTHI = 19'b0000_0000_0001_0110_000;
   localparam logic [18:0] X_MTLO = 19'b0000_0000_0001_0101_000;
   localparam logic [18:0] X_OUT  = 19'b0000_0000_0001_0100_100;

   logic       Clock = 1'b0;
   logic       clr   = 1'b0;
   logic       start = 1'b0;
   logic [4:0] opcode = 5'b0;

   wire [18:0] ctl_o [3];
   wire        ill_o [3];
   wire [7:0]  cnt_o [3];

   int checks   = 0;
   int failures = 0;

   int mw  [3] = '{1, 3, 2};
   int cwv [3] = '{8, 8, 2};
   int act [3];
   int ph  [3];
   int cnt [3];
   bit ill [3];

   always #5 Clock = ~Clock;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int MWG = (g == 0) ? 1 : ((g == 1) ? 3 : 2);
      localparam int CWG = (g == 2) ? 2 : 8;
      wire [CWG-1:0] c;
      move_special_ctrl #(.MEM_WAIT(MWG), .CW(CWG)) u_dut (
         .Clock(Clock), .clr(clr), .start(start), .ir_opcode(opcode),
         .PC_out(ctl_o[g][18]), .MAR_enable(ctl_o[g][17]), .PC_enable(ctl_o[g][16]),
         .IncPC(ctl_o[g][15]), .Read(ctl_o[g][14]), .MDR_enable(ctl_o[g][13]),
         .MDR_out(ctl_o[g][12]), .IR_enable(ctl_o[g][11]), .HI_out(ctl_o[g][10]),
         .LO_out(ctl_o[g][9]), .in_port_out(ctl_o[g][8]), .Gra(ctl_o[g][7]),
         .R_in(ctl_o[g][6]), .R_out(ctl_o[g][5]), .HI_enable(ctl_o[g][4]),
         .LO_enable(ctl_o[g][3]), .out_port_enable(ctl_o[g][2]), .busy(ctl_o[g][1]),
         .done(ctl_o[g][0]), .illegal(ill_o[g]), .instr_count(c)
      );
      assign cnt_o[g] = 8'(c);
   end

   function automatic logic [18:0] exec_mask(logic [4:0] op);
      case (op)
         OP_MFHI: return X_MFHI;
         OP_MFLO: return X_MFLO;
         OP_IN:   return X_IN;
         OP_MTHI: return X_MTHI;
         OP_MTLO: return X_MTLO;
         OP_OUT:  return X_OUT;
         default: return '0;
      endcase
   endfunction

   // Instruction position: 0 = fetch, 1..MEM_WAIT = read, then IR load, execute, done.
   function automatic logic [18:0] exp_ctl(int k);
      int m = mw[k];
      if (act[k] == 0)     return '0;
      if (ph[k] == 0)      return M_T0;
      if (ph[k] <= m)      return M_T1;
      if (ph[k] == m + 1)  return M_T2;
      if (ph[k] == m + 2)  return M_BUSY | exec_mask(opcode);
      return M_DONE;
   endfunction

   always @(posedge Clock or negedge clr) begin
      for (int k = 0; k < 3; k++) begin
         if (!clr) begin
            act[k] = 0; ph[k] = 0; cnt[k] = 0; ill[k] = 1'b0;
         end else if (act[k] == 0) begin
            if (start) begin act[k] = 1; ph[k] = 0; end
         end else if (ph[k] == mw[k] + 3) begin
            if (cnt[k] < (1 << cwv[k]) - 1) cnt[k] = cnt[k] + 1;
            if (start) ph[k] = 0;
            else       act[k] = 0;
         end else begin
            if (ph[k] == mw[k] + 2 && exec_mask(opcode) == '0) ill[k] = 1'b1;
            ph[k] = ph[k] + 1;
         end
      end
   end

   task automatic check(string name, int k, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s[%0d] got=%0h exp=%0h t=%0t", name, k, got, exp, $time);
      end
   endtask

   always @(negedge Clock) begin
      for (int k = 0; k < 3; k++) begin
         check("model_ctl", k, 32'(ctl_o[k]), 32'(exp_ctl(k)));
         check("model_illegal", k, 32'(ill_o[k]), 32'(ill[k]));
         check("model_count", k, 32'(cnt_o[k]), 32'(cnt[k]));
      end
   end

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic pulse_clr();
      tick();
      clr = 1'b0;
      tick();
      clr = 1'b1;
   endtask

   logic [18:0] mfhi_seq [6];
   logic [4:0]  b2b_ops  [3];
   logic [18:0] b2b_exec [3];
   int          sat_exp  [5];
   logic [4:0]  legal_ops [6];

   initial begin
      int reads, done_at;
      mfhi_seq  = '{M_T0, M_T1, M_T2, M_BUSY | X_MFHI, M_DONE, 19'b0};
      b2b_ops   = '{OP_MFLO, OP_IN, OP_OUT};
      b2b_exec  = '{X_MFLO, X_IN, X_OUT};
      sat_exp   = '{1, 2, 3, 3, 3};
      legal_ops = '{OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO, OP_IN, OP_OUT};

      repeat (2) tick();
      check("reset_ctl", 0, 32'(ctl_o[0]), 32'h0);
      check("reset_count", 0, 32'(cnt_o[0]), 32'h0);
      clr = 1'b1;
      repeat (2) tick();
      @(negedge Clock);
      check("post_reset_idle", 0, 32'(ctl_o[0]), 32'h0);

      // MFHI with one read cycle
      pulse_clr();
      start = 1'b1; opcode = OP_MFHI;
      for (int i = 0; i < 6; i++) begin
         tick(); start = 1'b0;
         @(negedge Clock);
         check("mfhi_seq", i, 32'(ctl_o[0]), 32'(mfhi_seq[i]));
      end
      check("mfhi_count", 0, 32'(cnt_o[0]), 32'd1);
      repeat (10) tick();

      // MTLO on the three-cycle-read instance
      pulse_clr();
      start = 1'b1; opcode = OP_MTLO;
      reads = 0; done_at = 0;
      for (int i = 1; i <= 10; i++) begin
         tick(); start = 1'b0;
         @(negedge Clock);
         if (ctl_o[1][14]) reads++;
         if (ctl_o[1][0] && done_at == 0) done_at = i;
         if (i == 6) check("mtlo_t3", 1, 32'(ctl_o[1]), 32'(M_BUSY | X_MTLO));
      end
      check("mtlo_read_cycles", 1, reads, 3);
      check("mtlo_done_cycle", 1, done_at, 7);
      check("mtlo_count", 1, 32'(cnt_o[1]), 32'd1);
      repeat (10) tick();

      // Back-to-back MFLO, IN, OUT with start held
      pulse_clr();
      start = 1'b1; opcode = b2b_ops[0];
      for (int i = 1; i <= 15; i++) begin
         tick();
         if (i == 15) start = 1'b0;
         opcode = b2b_ops[(i - 1) / 5];
         @(negedge Clock);
         check("b2b_done", i, 32'(ctl_o[0][0]), 32'(i % 5 == 0));
         check("b2b_busy", i, 32'(ctl_o[0][1]), 32'(i % 5 != 0));
         if (i % 5 == 4) check("b2b_exec", i, 32'(ctl_o[0]), 32'(M_BUSY | b2b_exec[i / 5]));
      end
      tick();
      @(negedge Clock);
      check("b2b_count", 0, 32'(cnt_o[0]), 32'd3);
      check("b2b_idle", 0, 32'(ctl_o[0]), 32'h0);
      repeat (10) tick();

      // Illegal opcode is sticky across a later legal instruction
      pulse_clr();
      start = 1'b1; opcode = 5'b00000;
      for (int i = 1; i <= 6; i++) begin
         tick(); start = 1'b0;
         @(negedge Clock);
         if (i == 4) check("illegal_t3", 0, 32'(ctl_o[0]), 32'(M_BUSY));
      end
      check("illegal_set", 0, 32'(ill_o[0]), 32'd1);
      repeat (4) tick();
      start = 1'b1; opcode = OP_MFHI;
      repeat (8) begin tick(); start = 1'b0; end
      @(negedge Clock);
      check("illegal_sticky", 0, 32'(ill_o[0]), 32'd1);
      check("illegal_count", 0, 32'(cnt_o[0]), 32'd2);
      pulse_clr();
      @(negedge Clock);
      check("illegal_cleared", 0, 32'(ill_o[0]), 32'd0);

      // Saturation on the CW=2 instance
      pulse_clr();
      for (int n = 0; n < 5; n++) begin
         tick();
         start = 1'b1; opcode = OP_MFHI;
         tick(); start = 1'b0;
         repeat (9) tick();
         @(negedge Clock);
         check("saturate", n, 32'(cnt_o[2]), 32'(sat_exp[n]));
      end

      // Asynchronous clear in the middle of a three-cycle read
      tick();
      start = 1'b1; opcode = OP_MFHI;
      tick(); start = 1'b0;
      tick();
      #1;
      check("midt1_before", 1, 32'(ctl_o[1]), 32'(M_T1));
      clr = 1'b0;
      #1;
      check("midt1_ctl", 1, 32'(ctl_o[1]), 32'h0);
      check("midt1_count", 1, 32'(cnt_o[1]), 32'h0);
      check("midt1_illegal", 1, 32'(ill_o[1]), 32'h0);
      tick(); clr = 1'b1;
      repeat (3) tick();
      @(negedge Clock);
      check("midt1_stays_idle", 1, 32'(ctl_o[1]), 32'h0);

      // Randomized traffic, checked every cycle by the model
      for (int i = 0; i < 3000; i++) begin
         tick();
         start  = ($urandom_range(0, 3) != 0);
         opcode = ($urandom_range(0, 9) < 8) ? legal_ops[$urandom_range(0, 5)]
                                             : 5'($urandom_range(0, 31));
         if ($urandom_range(0, 299) == 0) begin
            #2 clr = 1'b0;
            tick();
            clr = 1'b1;
         end
      end
      tick();
      @(negedge Clock);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
